// File: rtl/serial_compare_sequencer.sv
// ============================================================================
//  Module   : serial_compare_sequencer
//  Purpose  : Streams an operand pair MSB-first into a serial comparator and
//             collects its lt/eq/gt flags into a one-entry result register.
//  Options  : SERIAL_CMP_SELFCHECK_EN adds a parallel reference compare and a
//             sticky err flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_compare_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             ser_clear,
   output logic             ser_valid,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_last,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_lt,
   output logic             res_eq,
   output logic             res_gt,
   output logic             err
);

   localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ser_clear_q, ser_clear_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_a_q, ser_a_d;
   logic             ser_b_q, ser_b_d;
   logic             ser_last_q, ser_last_d;
   logic             res_valid_q, res_valid_d;
   logic             res_lt_q, res_lt_d;
   logic             res_eq_q, res_eq_d;
   logic             res_gt_q, res_gt_d;
   logic             accept;
   logic             capture;

   // The stream cannot stall, so a new pair is only taken once the result slot is free or draining.
   assign in_ready = (state_q == S_IDLE) && (!res_valid_q || res_ready);
   assign accept   = in_valid && in_ready;
   assign capture  = (state_q == S_SHIFT) && ser_last_q;

   always_comb begin
      state_d     = state_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      cnt_d       = cnt_q;
      ser_clear_d = 1'b0;
      ser_valid_d = 1'b0;
      ser_a_d     = 1'b0;
      ser_b_d     = 1'b0;
      ser_last_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sa_d        = in_a;
               sb_d        = in_b;
               ser_clear_d = 1'b1;
               state_d     = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d     = S_SHIFT;
            cnt_d       = CNT_INIT;
            ser_valid_d = 1'b1;
            ser_a_d     = sa_q[WIDTH-1];
            ser_b_d     = sb_q[WIDTH-1];
            sa_d        = sa_q << 1;
            sb_d        = sb_q << 1;
            ser_last_d  = (CNT_INIT == '0);
         end
         S_SHIFT: begin
            if (ser_last_q) begin
               state_d = S_IDLE;
            end else begin
               cnt_d       = cnt_q - 1'b1;
               ser_valid_d = 1'b1;
               ser_a_d     = sa_q[WIDTH-1];
               ser_b_d     = sb_q[WIDTH-1];
               sa_d        = sa_q << 1;
               sb_d        = sb_q << 1;
               ser_last_d  = (cnt_q == CNT_W'(1));
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      res_valid_d = res_valid_q && !res_ready;
      res_lt_d    = res_lt_q;
      res_eq_d    = res_eq_q;
      res_gt_d    = res_gt_q;
      if (capture) begin
         res_valid_d = 1'b1;
         res_lt_d    = cmp_lt;
         res_eq_d    = cmp_eq;
         res_gt_d    = cmp_gt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         sa_q        <= '0;
         sb_q        <= '0;
         cnt_q       <= '0;
         ser_clear_q <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_a_q     <= 1'b0;
         ser_b_q     <= 1'b0;
         ser_last_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_lt_q    <= 1'b0;
         res_eq_q    <= 1'b0;
         res_gt_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         cnt_q       <= cnt_d;
         ser_clear_q <= ser_clear_d;
         ser_valid_q <= ser_valid_d;
         ser_a_q     <= ser_a_d;
         ser_b_q     <= ser_b_d;
         ser_last_q  <= ser_last_d;
         res_valid_q <= res_valid_d;
         res_lt_q    <= res_lt_d;
         res_eq_q    <= res_eq_d;
         res_gt_q    <= res_gt_d;
      end
   end

   assign ser_clear = ser_clear_q;
   assign ser_valid = ser_valid_q;
   assign ser_a     = ser_a_q;
   assign ser_b     = ser_b_q;
   assign ser_last  = ser_last_q;
   assign res_valid = res_valid_q;
   assign res_lt    = res_lt_q;
   assign res_eq    = res_eq_q;
   assign res_gt    = res_gt_q;

`ifdef SERIAL_CMP_SELFCHECK_EN
   logic exp_lt_q, exp_lt_d;
   logic exp_eq_q, exp_eq_d;
   logic exp_gt_q, exp_gt_d;
   logic err_q, err_d;
   logic flags_onehot;

   always_comb begin
      exp_lt_d = exp_lt_q;
      exp_eq_d = exp_eq_q;
      exp_gt_d = exp_gt_q;
      if (accept) begin
         exp_lt_d = (in_a <  in_b);
         exp_eq_d = (in_a == in_b);
         exp_gt_d = (in_a >  in_b);
      end
      flags_onehot = (cmp_lt ^ cmp_eq ^ cmp_gt) && !(cmp_lt && cmp_eq && cmp_gt);
      err_d = err_q;
      if (capture && (!flags_onehot ||
                      ({cmp_lt, cmp_eq, cmp_gt} != {exp_lt_q, exp_eq_q, exp_gt_q}))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_lt_q <= 1'b0;
         exp_eq_q <= 1'b0;
         exp_gt_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         exp_lt_q <= exp_lt_d;
         exp_eq_q <= exp_eq_d;
         exp_gt_q <= exp_gt_d;
         err_q    <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_compare_sequencer.sv
// ============================================================================
//  Module   : tb_serial_compare_sequencer
//  Purpose  : Directed self-checking bench with a behavioural MSB-first
//             serial comparator attached to the sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_compare_sequencer;

`ifdef SERIAL_CMP_SELFCHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;
   logic       ser_clear, ser_valid, ser_a, ser_b, ser_last;
   logic       cmp_lt, cmp_eq, cmp_gt;
   logic       res_valid;
   logic       res_ready = 1'b1;
   logic       res_lt, res_eq, res_gt;
   logic       err;

   logic       force_lt = 1'b0;
   logic       dec_lt = 1'b0;
   logic       dec_gt = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_compare_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .ser_clear (ser_clear),
      .ser_valid (ser_valid),
      .ser_a     (ser_a),
      .ser_b     (ser_b),
      .ser_last  (ser_last),
      .cmp_lt    (cmp_lt),
      .cmp_eq    (cmp_eq),
      .cmp_gt    (cmp_gt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_lt    (res_lt),
      .res_eq    (res_eq),
      .res_gt    (res_gt),
      .err       (err)
   );

   // Serial comparator: first differing bit decides, cleared synchronously by ser_clear.
   always @(posedge clk) begin
      if (ser_clear) begin
         dec_lt <= 1'b0;
         dec_gt <= 1'b0;
      end else if (ser_valid && !dec_lt && !dec_gt) begin
         dec_lt <= !ser_a && ser_b;
         dec_gt <= ser_a && !ser_b;
      end
   end

   assign cmp_lt = force_lt | dec_lt | (!dec_lt && !dec_gt && !ser_a && ser_b);
   assign cmp_gt = dec_gt | (!dec_lt && !dec_gt && ser_a && !ser_b);
   assign cmp_eq = !dec_lt && !dec_gt && (ser_a == ser_b);

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, exp);
   endtask

   task automatic run_word(input logic [7:0] a, input logic [7:0] b,
                           input logic elt, input logic eeq, input logic egt);
      @(negedge clk);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      check("in_ready_idle", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("clear_pulse", ser_clear, 1'b1);
      check("clear_no_valid", ser_valid, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bit%0d_valid", k), ser_valid, 1'b1);
         check($sformatf("bit%0d_a", k), ser_a, a[7-k]);
         check($sformatf("bit%0d_b", k), ser_b, b[7-k]);
         check($sformatf("bit%0d_last", k), ser_last, (k == 7));
         check($sformatf("bit%0d_clear", k), ser_clear, 1'b0);
      end
      @(posedge clk);
      #1;
      check("res_valid", res_valid, 1'b1);
      check("res_lt", res_lt, elt);
      check("res_eq", res_eq, eeq);
      check("res_gt", res_gt, egt);
      check("stream_done", ser_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2;
      check("rst_ser_clear", ser_clear, 1'b0);
      check("rst_ser_valid", ser_valid, 1'b0);
      check("rst_ser_last", ser_last, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_eq", res_eq, 1'b0);
      check("rst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_in_ready", in_ready, 1'b1);

      run_word(8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
      check("eq_err", err, 1'b0);
      run_word(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1);
      run_word(8'h12, 8'h13, 1'b1, 1'b0, 1'b0);

      // Back-pressure: two pairs offered back to back, result slot held.
      @(negedge clk);
      res_ready = 1'b0;
      in_a      = 8'h10;
      in_b      = 8'h20;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_a = 8'hFF;
      in_b = 8'h00;
      check("bp_busy_clear", in_ready, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_lt", res_lt, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_ready", i), in_ready, 1'b0);
         check($sformatf("bp_hold%0d_valid", i), res_valid, 1'b1);
         check($sformatf("bp_hold%0d_lt", i), res_lt, 1'b1);
         check($sformatf("bp_hold%0d_gt", i), res_gt, 1'b0);
         check($sformatf("bp_hold%0d_clear", i), ser_clear, 1'b0);
      end
      @(negedge clk);
      res_ready = 1'b1;
      #1 check("bp_release_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      check("bp2_clear", ser_clear, 1'b1);
      check("bp_popped", res_valid, 1'b0);
      @(posedge clk);
      #1;
      check("bp2_ignore_valid", in_ready, 1'b0);
      check("bp2_bit0_valid", ser_valid, 1'b1);
      check("bp2_bit0_a", ser_a, 1'b1);
      check("bp2_bit0_b", ser_b, 1'b0);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("bp2_res_valid", res_valid, 1'b1);
      check("bp2_res_gt", res_gt, 1'b1);
      check("bp2_res_lt", res_lt, 1'b0);

      // Asynchronous reset in the middle of a stream.
      @(negedge clk);
      in_a     = 8'hC3;
      in_b     = 8'h3C;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_ser_valid", ser_valid, 1'b0);
      check("arst_ser_a", ser_a, 1'b0);
      check("arst_ser_last", ser_last, 1'b0);
      check("arst_ser_clear", ser_clear, 1'b0);
      check("arst_res_valid", res_valid, 1'b0);
      check("arst_res_gt", res_gt, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("arst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 check("arst_no_result", res_valid, 1'b0);
      run_word(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);

      // Faulty comparator flags followed by a correct word.
      force_lt = 1'b1;
      run_word(8'h33, 8'h33, 1'b1, 1'b1, 1'b0);
      check("selfcheck_err", err, EXP_ERR);
      force_lt = 1'b0;
      run_word(8'h44, 8'h40, 1'b0, 1'b0, 1'b1);
      check("selfcheck_sticky", err, EXP_ERR);
      @(negedge clk);
      rst = 1'b0;
      #1 check("selfcheck_err_reset", err, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
